// File: rtl/cv32e40x_data_obi_responder.sv
// cv32e40x_data_obi_responder: OBI data-side memory model with byte-enable writes,
// range checking and an in-order response FIFO that bounds outstanding transfers.
module cv32e40x_data_obi_responder #(
    parameter int MEM_WORDS       = 1024,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        gnt_stall_i,
    input  logic        rsp_stall_i
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   mem_q [MEM_WORDS];
    logic [31:0]   fifo_rdata_q [MAX_OUTSTANDING];
    logic          fifo_err_q [MAX_OUTSTANDING];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] idx;
    logic          in_range, push, pop;
    logic [31:0]   rsp_rdata;
    logic          unused_addr_lsb;

    assign idx             = addr_i[AW+1:2];
    assign in_range        = (addr_i[31:AW+2] == '0);
    assign unused_addr_lsb = ^addr_i[1:0];

    // Grant depends only on registered occupancy so a same-cycle pop never widens it.
    assign gnt_o     = rst_n && req_i && !gnt_stall_i && (count_q < CW'(MAX_OUTSTANDING));
    assign push      = req_i && gnt_o;
    assign rvalid_o  = (count_q != '0) && !rsp_stall_i;
    assign pop       = rvalid_o;
    assign rdata_o   = rvalid_o ? fifo_rdata_q[rptr_q] : '0;
    assign err_o     = rvalid_o ? fifo_err_q[rptr_q] : 1'b0;
    assign rsp_rdata = (we_i || !in_range) ? '0 : mem_q[idx];
    assign wptr_d    = !push ? wptr_q : (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
    assign rptr_d    = !pop ? rptr_q : (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (push && we_i && in_range) begin
            for (int b = 0; b < 4; b++) if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_rdata_q[i] <= '0;
                fifo_err_q[i]   <= 1'b0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_rdata_q[wptr_q] <= rsp_rdata;
                fifo_err_q[wptr_q]   <= !in_range;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule
